// File: rtl/alu_rs_if.sv
// Bundle between the RS arbiter, the CDB and the ALU for the ALU reservation station.
// The station connects through the slave modport; the driving environment uses master.
interface alu_rs_if #(
    parameter int WIDTH = 31,
    parameter int ALU   = 3,
    parameter int ROB   = 4,
    parameter int OP    = 3
);
    logic             flush;
    logic [ALU:0]     ALURequests;
    logic [OP:0]      aluOp;
    logic [WIDTH:0]   src1;
    logic [WIDTH:0]   src2;
    logic             ready1;
    logic             ready2;
    logic [ROB:0]     tag1;
    logic [ROB:0]     tag2;
    logic [ROB:0]     destROB;
    logic             cdbValid;
    logic [ROB:0]     cdbTag;
    logic [WIDTH:0]   cdbData;
    logic [ALU:0]     ALUBusyVector;
    logic             ALUFull;
    logic             issueValid;
    logic             issueReady;
    logic [OP:0]      issueOp;
    logic [WIDTH:0]   issueA;
    logic [WIDTH:0]   issueB;
    logic [ROB:0]     issueROB;

    modport slave (
        input  flush, ALURequests, aluOp, src1, src2, ready1, ready2, tag1, tag2, destROB,
        input  cdbValid, cdbTag, cdbData, issueReady,
        output ALUBusyVector, ALUFull, issueValid, issueOp, issueA, issueB, issueROB
    );

    modport master (
        output flush, ALURequests, aluOp, src1, src2, ready1, ready2, tag1, tag2, destROB,
        output cdbValid, cdbTag, cdbData, issueReady,
        input  ALUBusyVector, ALUFull, issueValid, issueOp, issueA, issueB, issueROB
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: ALU+1 entries, CDB wakeup, lowest-index select and a
// registered valid/ready issue stage. All outputs come straight from flops.
module alu_reservation_station #(
    parameter int WIDTH = 31,
    parameter int ALU   = 3,
    parameter int ROB   = 4,
    parameter int OP    = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_rs_if.slave  bus
);
    localparam logic [ALU:0] ONE_VEC = {{ALU{1'b0}}, 1'b1};

    logic [ALU:0]   busy_q, busy_d;
    logic [ALU:0]   rdy1_q, rdy1_d;
    logic [ALU:0]   rdy2_q, rdy2_d;
    logic [OP:0]    op_q    [ALU:0];
    logic [OP:0]    op_d    [ALU:0];
    logic [WIDTH:0] val1_q  [ALU:0];
    logic [WIDTH:0] val1_d  [ALU:0];
    logic [WIDTH:0] val2_q  [ALU:0];
    logic [WIDTH:0] val2_d  [ALU:0];
    logic [ROB:0]   tag1_q  [ALU:0];
    logic [ROB:0]   tag1_d  [ALU:0];
    logic [ROB:0]   tag2_q  [ALU:0];
    logic [ROB:0]   tag2_d  [ALU:0];
    logic [ROB:0]   dest_q  [ALU:0];
    logic [ROB:0]   dest_d  [ALU:0];

    logic           iss_valid_q, iss_valid_d;
    logic [OP:0]    iss_op_q, iss_op_d;
    logic [WIDTH:0] iss_a_q, iss_a_d;
    logic [WIDTH:0] iss_b_q, iss_b_d;
    logic [ROB:0]   iss_rob_q, iss_rob_d;

    logic [ALU:0]   elig_s;
    logic [ALU:0]   sel_oh_s;
    logic           one_hot_s;
    logic           wr_en_s;
    logic           load_s;

    // Eligibility, selection and write-legality decode from registered state and inputs
    always_comb begin
        elig_s    = busy_q & rdy1_q & rdy2_q;
        sel_oh_s  = elig_s & (~elig_s + ONE_VEC);
        one_hot_s = (bus.ALURequests != '0) &&
                    ((bus.ALURequests & (bus.ALURequests - ONE_VEC)) == '0);
        wr_en_s   = one_hot_s && ((bus.ALURequests & busy_q) == '0) && !bus.flush;
        load_s    = (!iss_valid_q || bus.issueReady) && (elig_s != '0);
    end

    // Next-state: flush, CDB wakeup, issue load/drain and entry write
    always_comb begin
        busy_d      = busy_q;
        rdy1_d      = rdy1_q;
        rdy2_d      = rdy2_q;
        op_d        = op_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        tag1_d      = tag1_q;
        tag2_d      = tag2_q;
        dest_d      = dest_q;
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_rob_d   = iss_rob_q;

        if (bus.flush) begin
            busy_d      = '0;
            iss_valid_d = 1'b0;
        end else begin
            for (int i = 0; i <= ALU; i++) begin
                if (busy_q[i] && !rdy1_q[i] && bus.cdbValid && (tag1_q[i] == bus.cdbTag)) begin
                    val1_d[i] = bus.cdbData;
                    rdy1_d[i] = 1'b1;
                end else begin
                    val1_d[i] = val1_q[i];
                end
                if (busy_q[i] && !rdy2_q[i] && bus.cdbValid && (tag2_q[i] == bus.cdbTag)) begin
                    val2_d[i] = bus.cdbData;
                    rdy2_d[i] = 1'b1;
                end else begin
                    val2_d[i] = val2_q[i];
                end
            end

            if (load_s) begin
                iss_valid_d = 1'b1;
                for (int i = 0; i <= ALU; i++) begin
                    if (sel_oh_s[i]) begin
                        iss_op_d  = op_q[i];
                        iss_a_d   = val1_q[i];
                        iss_b_d   = val2_q[i];
                        iss_rob_d = dest_q[i];
                        busy_d[i] = 1'b0;
                    end else begin
                        busy_d[i] = busy_q[i];
                    end
                end
            end else if (iss_valid_q && bus.issueReady) begin
                iss_valid_d = 1'b0;
            end else begin
                iss_valid_d = iss_valid_q;
            end

            // The written entry is never busy, so it cannot collide with the issued one
            for (int i = 0; i <= ALU; i++) begin
                if (wr_en_s && bus.ALURequests[i]) begin
                    busy_d[i] = 1'b1;
                    op_d[i]   = bus.aluOp;
                    tag1_d[i] = bus.tag1;
                    tag2_d[i] = bus.tag2;
                    dest_d[i] = bus.destROB;
                    if (!bus.ready1 && bus.cdbValid && (bus.cdbTag == bus.tag1)) begin
                        val1_d[i] = bus.cdbData;
                        rdy1_d[i] = 1'b1;
                    end else begin
                        val1_d[i] = bus.src1;
                        rdy1_d[i] = bus.ready1;
                    end
                    if (!bus.ready2 && bus.cdbValid && (bus.cdbTag == bus.tag2)) begin
                        val2_d[i] = bus.cdbData;
                        rdy2_d[i] = 1'b1;
                    end else begin
                        val2_d[i] = bus.src2;
                        rdy2_d[i] = bus.ready2;
                    end
                end else begin
                    op_d[i] = op_q[i];
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            for (int i = 0; i <= ALU; i++) begin
                op_q[i]   <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                dest_q[i] <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_rob_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
            op_q        <= op_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            dest_q      <= dest_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_rob_q   <= iss_rob_d;
        end
    end

    assign bus.ALUBusyVector = busy_q;
    assign bus.ALUFull       = &busy_q;
    assign bus.issueValid    = iss_valid_q;
    assign bus.issueOp       = iss_op_q;
    assign bus.issueA        = iss_a_q;
    assign bus.issueB        = iss_b_q;
    assign bus.issueROB      = iss_rob_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: linear steps with hand-computed expectations.
module tb_alu_reservation_station;
    logic clk;
    logic rst_n;
    int   total_cnt;
    int   pass_cnt;

    alu_rs_if bus ();

    alu_reservation_station dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] req, input logic [31:0] a, input logic ra, input logic [4:0] ta,
                      input logic [31:0] b, input logic rb, input logic [4:0] tb2, input logic [3:0] op,
                      input logic [4:0] dest);
        bus.ALURequests = req;
        bus.src1 = a;  bus.ready1 = ra; bus.tag1 = ta;
        bus.src2 = b;  bus.ready2 = rb; bus.tag2 = tb2;
        bus.aluOp = op; bus.destROB = dest;
    endtask

    task automatic cdb(input logic v, input logic [4:0] t, input logic [31:0] d);
        bus.cdbValid = v; bus.cdbTag = t; bus.cdbData = d;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.issueReady = 1'b1;
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        cdb(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("rst_busy",  {28'd0, bus.ALUBusyVector}, 32'h0);
        chk("rst_full",  {31'd0, bus.ALUFull}, 32'h0);
        chk("rst_valid", {31'd0, bus.issueValid}, 32'h0);
        chk("rst_a",     bus.issueA, 32'h0);
        rst_n = 1'b1;
        tick();

        // Ready write: visible on issue one edge after the write edge
        wr(4'b0001, 32'd5, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 4'd3, 5'd2);
        tick();
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        chk("w_busy",    {28'd0, bus.ALUBusyVector}, 32'h1);
        chk("w_nv",      {31'd0, bus.issueValid}, 32'h0);
        tick();
        chk("w_valid",   {31'd0, bus.issueValid}, 32'h1);
        chk("w_a",       bus.issueA, 32'd5);
        chk("w_b",       bus.issueB, 32'd7);
        chk("w_op",      {28'd0, bus.issueOp}, 32'd3);
        chk("w_rob",     {27'd0, bus.issueROB}, 32'd2);
        chk("w_free",    {28'd0, bus.ALUBusyVector}, 32'h0);
        tick();
        chk("w_drain",   {31'd0, bus.issueValid}, 32'h0);

        // Wakeup: operand 2 waits on tag 9
        wr(4'b0010, 32'd1, 1'b1, 5'd0, 32'h55, 1'b0, 5'd9, 4'd1, 5'd4);
        tick();
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        chk("wk_busy",   {28'd0, bus.ALUBusyVector}, 32'h2);
        tick();
        chk("wk_wait",   {31'd0, bus.issueValid}, 32'h0);
        cdb(1'b1, 5'd9, 32'hAB);
        tick();
        cdb(1'b0, 5'd0, 32'd0);
        chk("wk_early",  {31'd0, bus.issueValid}, 32'h0);
        chk("wk_held",   {28'd0, bus.ALUBusyVector}, 32'h2);
        tick();
        chk("wk_valid",  {31'd0, bus.issueValid}, 32'h1);
        chk("wk_b",      bus.issueB, 32'hAB);
        chk("wk_a",      bus.issueA, 32'd1);
        chk("wk_rob",    {27'd0, bus.issueROB}, 32'd4);
        tick();

        // Write-time bypass: CDB matches tag2 in the write cycle
        wr(4'b0100, 32'd3, 1'b1, 5'd0, 32'd0, 1'b0, 5'd7, 4'd2, 5'd6);
        cdb(1'b1, 5'd7, 32'h77);
        tick();
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        cdb(1'b0, 5'd0, 32'd0);
        tick();
        chk("bp_valid",  {31'd0, bus.issueValid}, 32'h1);
        chk("bp_b",      bus.issueB, 32'h77);
        tick();
        chk("bp_drain",  {31'd0, bus.issueValid}, 32'h0);

        // Backpressure: fill all entries, issue register holds the first entry 0
        bus.issueReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(4'b0001 << i, 32'd10 + 32'(i), 1'b1, 5'd0, 32'd20 + 32'(i), 1'b1, 5'd0, 4'd0, 5'(i));
            tick();
        end
        wr(4'b0001, 32'd30, 1'b1, 5'd0, 32'd40, 1'b1, 5'd0, 4'd0, 5'd8);
        tick();
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        chk("bk_full",   {31'd0, bus.ALUFull}, 32'h1);
        chk("bk_busy",   {28'd0, bus.ALUBusyVector}, 32'hF);
        chk("bk_valid",  {31'd0, bus.issueValid}, 32'h1);
        chk("bk_a0",     bus.issueA, 32'd10);
        tick();
        chk("bk_hold",   bus.issueA, 32'd10);
        chk("bk_hbusy",  {28'd0, bus.ALUBusyVector}, 32'hF);
        bus.issueReady = 1'b1;
        tick();
        chk("bk_e0",     bus.issueA, 32'd30);
        chk("bk_e0b",    {28'd0, bus.ALUBusyVector}, 32'hE);
        tick();
        chk("bk_e1",     bus.issueA, 32'd11);
        chk("bk_e1b",    {28'd0, bus.ALUBusyVector}, 32'hC);
        tick();
        chk("bk_e2",     bus.issueA, 32'd12);
        tick();
        chk("bk_e3",     bus.issueA, 32'd13);
        chk("bk_e3rob",  {27'd0, bus.issueROB}, 32'd3);
        chk("bk_empty",  {28'd0, bus.ALUBusyVector}, 32'h0);
        tick();
        chk("bk_drain",  {31'd0, bus.issueValid}, 32'h0);

        // Illegal writes: multi-hot request and write to a busy entry are ignored
        wr(4'b0001, 32'd1, 1'b1, 5'd0, 32'd0, 1'b0, 5'd3, 4'd0, 5'd1);
        tick();
        wr(4'b0011, 32'h99, 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 4'd0, 5'd0);
        tick();
        chk("il_multi",  {28'd0, bus.ALUBusyVector}, 32'h1);
        wr(4'b0001, 32'h99, 1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 4'd0, 5'd0);
        tick();
        chk("il_busy",   {28'd0, bus.ALUBusyVector}, 32'h1);
        chk("il_nv",     {31'd0, bus.issueValid}, 32'h0);
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        cdb(1'b1, 5'd3, 32'h33);
        tick();
        cdb(1'b0, 5'd0, 32'd0);
        tick();
        chk("il_valid",  {31'd0, bus.issueValid}, 32'h1);
        chk("il_a",      bus.issueA, 32'd1);
        chk("il_b",      bus.issueB, 32'h33);
        chk("il_rob",    {27'd0, bus.issueROB}, 32'd1);
        tick();

        // Flush with a concurrent write
        bus.issueReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(4'b0001 << i, 32'h60 + 32'(i), 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 4'd0, 5'd0);
            tick();
        end
        chk("fl_pre",    {28'd0, bus.ALUBusyVector}, 32'hE);
        chk("fl_prev",   {31'd0, bus.issueValid}, 32'h1);
        wr(4'b0001, 32'h70, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 4'd0, 5'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        chk("fl_busy",   {28'd0, bus.ALUBusyVector}, 32'h0);
        chk("fl_valid",  {31'd0, bus.issueValid}, 32'h0);
        bus.issueReady = 1'b1;
        tick();
        chk("fl_nowr",   {31'd0, bus.issueValid}, 32'h0);
        chk("fl_empty",  {28'd0, bus.ALUBusyVector}, 32'h0);

        // Asynchronous reset mid-run with entries busy and issue valid
        bus.issueReady = 1'b0;
        wr(4'b0001, 32'h5, 1'b1, 5'd0, 32'h6, 1'b1, 5'd0, 4'd0, 5'd0);
        tick();
        wr(4'b0010, 32'h5, 1'b1, 5'd0, 32'h6, 1'b1, 5'd0, 4'd0, 5'd0);
        tick();
        wr(4'b0100, 32'h5, 1'b1, 5'd0, 32'h6, 1'b1, 5'd0, 4'd0, 5'd0);
        tick();
        wr(4'b0000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 4'd0, 5'd0);
        chk("ar_pre",    {28'd0, bus.ALUBusyVector}, 32'h6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",   {28'd0, bus.ALUBusyVector}, 32'h0);
        chk("ar_valid",  {31'd0, bus.issueValid}, 32'h0);
        chk("ar_a",      bus.issueA, 32'h0);
        tick();
        rst_n = 1'b1;
        bus.issueReady = 1'b1;
        tick();
        chk("ar_idle",   {31'd0, bus.issueValid}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
